// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter/sequencer (IDLE->ACCESS->RESP) in front of the byte/word RAM controller.
// Define RAM_ARB_ALIGN_CHECK_EN to flag odd-address word accesses with err instead of issuing them.
module ram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int PRIO_FIXED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic              p0_is_byte_i,
    input  logic              p0_we_i,
    input  logic [DATA_W-1:0] p0_wdata_i,
    output logic              p0_ack_o,
    output logic [DATA_W-1:0] p0_rdata_o,
    input  logic              p1_req_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic              p1_is_byte_i,
    input  logic              p1_we_i,
    input  logic [DATA_W-1:0] p1_wdata_i,
    output logic              p1_ack_o,
    output logic [DATA_W-1:0] p1_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_is_byte_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic gnt_q, gnt_d, last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic ram_is_byte_q, ram_is_byte_d, ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d, err_q, err_d;
    logic sel, sel_is_byte, sel_we, misalign;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    // Under conflict, round-robin favours the port that was not served last.
    assign sel         = (p0_req_i & p1_req_i) ? ((PRIO_FIXED != 0) ? 1'b0 : ~last_gnt_q) : p1_req_i;
    assign sel_addr    = sel ? p1_addr_i : p0_addr_i;
    assign sel_is_byte = sel ? p1_is_byte_i : p0_is_byte_i;
    assign sel_we      = sel ? p1_we_i : p0_we_i;
    assign sel_wdata   = sel ? p1_wdata_i : p0_wdata_i;
`ifdef RAM_ARB_ALIGN_CHECK_EN
    assign misalign = ~sel_is_byte & sel_addr[0];
`else
    assign misalign = 1'b0;
`endif
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_gnt_d    = last_gnt_q;
        ram_addr_d    = ram_addr_q;
        ram_is_byte_d = ram_is_byte_q;
        ram_wdata_d   = ram_wdata_q;
        ram_we_d      = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: if (p0_req_i | p1_req_i) begin
                gnt_d         = sel;
                ram_addr_d    = sel_addr;
                ram_is_byte_d = sel_is_byte;
                ram_wdata_d   = sel_wdata;
                if (misalign) begin
                    state_d  = RESP;
                    ack0_d   = ~sel;
                    ack1_d   = sel;
                    rdata0_d = sel ? rdata0_q : '0;
                    rdata1_d = sel ? '0 : rdata1_q;
                    err_d    = 1'b1;
                end else begin
                    state_d  = ACCESS;
                    ram_we_d = sel_we;
                end
            end
            ACCESS: begin
                state_d  = RESP;
                ack0_d   = ~gnt_q;
                ack1_d   = gnt_q;
                rdata0_d = (~gnt_q & ~ram_we_q) ? ram_rdata_i : rdata0_q;
                rdata1_d = (gnt_q & ~ram_we_q) ? ram_rdata_i : rdata1_q;
            end
            RESP: begin
                state_d    = IDLE;
                last_gnt_d = gnt_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_gnt_q    <= 1'b1;
            ram_addr_q    <= '0;
            ram_is_byte_q <= 1'b0;
            ram_wdata_q   <= '0;
            ram_we_q      <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_gnt_q    <= last_gnt_d;
            ram_addr_q    <= ram_addr_d;
            ram_is_byte_q <= ram_is_byte_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_we_q      <= ram_we_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end
    assign ram_addr_o    = ram_addr_q;
    assign ram_is_byte_o = ram_is_byte_q;
    assign ram_wdata_o   = ram_wdata_q;
    assign ram_we_o      = ram_we_q;
    assign p0_ack_o      = ack0_q;
    assign p1_ack_o      = ack1_q;
    assign p0_rdata_o    = rdata0_q;
    assign p1_rdata_o    = rdata1_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;
endmodule
